// File: rtl/mux_pkg.sv
// Shared limits and select-range helper for the parameterized select multiplexers.
package mux_pkg;

  localparam int unsigned MAX_WAY   = 8;
  localparam int unsigned MAX_WIDTH = 64;

  // The select value is already zero-extended by the caller, so the compare is unsigned.
  function automatic bit sel_in_range(input logic [31:0] sel, input int unsigned way);
    return sel < way;
  endfunction

endpackage

// File: rtl/mux_reg.sv
// Asynchronously reset register that holds the pipelined mux output and range flag.
module mux_reg #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/param_mux.sv
// N-way, WIDTH-bit binary-select multiplexer with a combinational output,
// a registered copy and a registered select-out-of-range flag.
module param_mux
  import mux_pkg::*;
#(
  parameter int unsigned WAY   = 2,
  parameter int unsigned SEL_W = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_err
);

  localparam int unsigned SX_W = (SEL_W > 4) ? SEL_W : 4;

  if (WAY < 2 || WAY > MAX_WAY) begin : g_bad_way
    $fatal(1, "param_mux: WAY=%0d outside 2..%0d", WAY, MAX_WAY);
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "param_mux: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if ((1 << SEL_W) < WAY) begin : g_bad_sel_w
    $fatal(1, "param_mux: SEL_W=%0d cannot address WAY=%0d inputs", SEL_W, WAY);
  end

  logic [WIDTH-1:0] w_d_arr [MAX_WAY];
  logic [SX_W-1:0]  w_sel_ext;
  logic             w_in_range;
  logic [WIDTH:0]   w_reg_q;

  assign w_d_arr[0] = d0;
  assign w_d_arr[1] = d1;
  assign w_d_arr[2] = d2;
  assign w_d_arr[3] = d3;
  assign w_d_arr[4] = d4;
  assign w_d_arr[5] = d5;
  assign w_d_arr[6] = d6;
  assign w_d_arr[7] = d7;

  assign w_sel_ext = SX_W'(s);

  // Priority chain of conditionals: an X select merges the candidates to X
  // instead of silently falling through to the zero default.
  logic [WIDTH-1:0] w_chain [WAY+1];
  assign w_chain[0] = '0;

  for (genvar i = 0; i < WAY; i++) begin : g_sel
    assign w_chain[i+1] = (w_sel_ext == SX_W'(i)) ? w_d_arr[i] : w_chain[i];
  end

  assign y          = w_chain[WAY];
  assign w_in_range = sel_in_range(32'(w_sel_ext), WAY);

  mux_reg #(
    .W (WIDTH + 1)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .d   ({~w_in_range, y}),
    .q   (w_reg_q)
  );

  assign sel_err = w_reg_q[WIDTH];
  assign y_q     = w_reg_q[WIDTH-1:0];

endmodule

// File: tb/tb_param_mux.sv
// Scoreboard bench for param_mux in three configurations sharing one clock and reset.
module tb_param_mux;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [0:0]  s_a;
  logic [1:0]  s_b;
  logic [2:0]  s_c;
  logic [63:0] d_a [8];
  logic [63:0] d_b [8];
  logic [63:0] d_c [8];

  logic [31:0] y_a, yq_a;
  logic [7:0]  y_b, yq_b;
  logic [63:0] y_c, yq_c;
  logic        err_a, err_b, err_c;

  param_mux #(.WAY(2), .SEL_W(1), .WIDTH(32)) u_dut_a (
    .clk (clk), .rst (rst), .s (s_a),
    .d0 (d_a[0][31:0]), .d1 (d_a[1][31:0]), .d2 (d_a[2][31:0]), .d3 (d_a[3][31:0]),
    .d4 (d_a[4][31:0]), .d5 (d_a[5][31:0]), .d6 (d_a[6][31:0]), .d7 (d_a[7][31:0]),
    .y (y_a), .y_q (yq_a), .sel_err (err_a)
  );

  param_mux #(.WAY(3), .SEL_W(2), .WIDTH(8)) u_dut_b (
    .clk (clk), .rst (rst), .s (s_b),
    .d0 (d_b[0][7:0]), .d1 (d_b[1][7:0]), .d2 (d_b[2][7:0]), .d3 (d_b[3][7:0]),
    .d4 (d_b[4][7:0]), .d5 (d_b[5][7:0]), .d6 (d_b[6][7:0]), .d7 (d_b[7][7:0]),
    .y (y_b), .y_q (yq_b), .sel_err (err_b)
  );

  param_mux #(.WAY(8), .SEL_W(3), .WIDTH(64)) u_dut_c (
    .clk (clk), .rst (rst), .s (s_c),
    .d0 (d_c[0]), .d1 (d_c[1]), .d2 (d_c[2]), .d3 (d_c[3]),
    .d4 (d_c[4]), .d5 (d_c[5]), .d6 (d_c[6]), .d7 (d_c[7]),
    .y (y_c), .y_q (yq_c), .sel_err (err_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [63:0] yq;
    logic        err;
  } exp_t;

  exp_t sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_y(input int unsigned way, input int unsigned width,
                                          input int unsigned sel, input logic [63:0] d [8]);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    if (sel < way) return d[sel] & mask;
    return 64'd0;
  endfunction

  function automatic logic [63:0] obs_y(input int dut);
    case (dut)
      0:       return 64'(y_a);
      1:       return 64'(y_b);
      default: return y_c;
    endcase
  endfunction

  function automatic logic [63:0] obs_yq(input int dut);
    case (dut)
      0:       return 64'(yq_a);
      1:       return 64'(yq_b);
      default: return yq_c;
    endcase
  endfunction

  function automatic logic obs_err(input int dut);
    case (dut)
      0:       return err_a;
      1:       return err_b;
      default: return err_c;
    endcase
  endfunction

  // Drive selects (called away from the clock edge), check the combinational
  // outputs at once, queue the registered expectations, then retire them after the edge.
  task automatic step(input int xa, input int xb, input int xc);
    logic [63:0] ey [3];
    s_a = 1'(xa);
    s_b = 2'(xb);
    s_c = 3'(xc);
    ey[0] = model_y(2, 32, xa, d_a);
    ey[1] = model_y(3, 8,  xb, d_b);
    ey[2] = model_y(8, 64, xc, d_c);
    #1;
    check($sformatf("y_a s=%0d", xa), obs_y(0), ey[0]);
    check($sformatf("y_b s=%0d", xb), obs_y(1), ey[1]);
    check($sformatf("y_c s=%0d", xc), obs_y(2), ey[2]);
    sb_q.push_back('{$sformatf("a s=%0d", xa), 0, ey[0], xa >= 2});
    sb_q.push_back('{$sformatf("b s=%0d", xb), 1, ey[1], xb >= 3});
    sb_q.push_back('{$sformatf("c s=%0d", xc), 2, ey[2], xc >= 8});
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({"y_q ", e.tag}, obs_yq(e.dut), e.yq);
      check({"sel_err ", e.tag}, 64'(obs_err(e.dut)), 64'(e.err));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_a = '0;
    s_b = '0;
    s_c = '0;
    for (int i = 0; i < 8; i++) begin
      d_a[i] = 64'hDEAD_BEE0 + 64'(i);
      d_b[i] = 64'h5A;
      d_c[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    end
    d_a[0] = 64'h0000_0010;
    d_a[1] = 64'h0000_0100;
    d_b[0] = 64'hA1;
    d_b[1] = 64'hB2;
    d_b[2] = 64'hC3;

    // Reset state, with the combinational path already live.
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset y_q dut%0d", k), obs_yq(k), 64'd0);
      check($sformatf("reset sel_err dut%0d", k), 64'(obs_err(k)), 64'd0);
    end
    check("reset y_a", obs_y(0), 64'h10);
    check("reset y_c", obs_y(2), 64'h1111_1111_1111_1111);

    @(negedge clk);
    rst = 1'b0;

    // Directed sweep: a toggles, b crosses its out-of-range code, c walks 0..7.
    step(0, 2, 0);
    step(1, 3, 1);
    step(0, 0, 2);
    step(1, 1, 3);
    step(0, 3, 4);
    step(1, 2, 5);
    step(0, 3, 6);
    step(1, 3, 7);

    // Asynchronous reset between edges while y_q and sel_err are nonzero.
    #2;
    rst = 1'b1;
    #1;
    check("async rst y_q_a", obs_yq(0), 64'd0);
    check("async rst sel_err_b", 64'(obs_err(1)), 64'd0);
    check("async rst y_q_c", obs_yq(2), 64'd0);
    s_a = 1'b0;
    s_c = 3'd2;
    #1;
    check("y_a tracks in rst", obs_y(0), 64'h10);
    check("y_c tracks in rst", obs_y(2), 64'h3333_3333_3333_3333);
    @(posedge clk);
    #1;
    check("y_q_a held in rst", obs_yq(0), 64'd0);
    check("sel_err_b held in rst", 64'(obs_err(1)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    step(1, 3, 5);

    // Data and select changing together on every step.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++) begin
        d_a[i] = {$urandom, $urandom};
        d_b[i] = {$urandom, $urandom};
        d_c[i] = {$urandom, $urandom};
      end
      step(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(7, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
